// File: rtl/nco_mc.sv
// nco_mc: time-multiplexed multi-channel NCO producing {sin, cos} samples
// from a quarter-wave LUT through a four-stage, backpressure-aware pipeline.
module nco_mc #(
    parameter int unsigned PHASE_DW      = 16,
    parameter int unsigned OUT_DW        = 16,
    parameter int unsigned NUM_CH        = 4,
    parameter bit          NEGATIVE_SINE = 1'b0,
    localparam int unsigned CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  run,
    input  logic                  phase_clear,
    input  logic [2*PHASE_DW-1:0] s_axis_cfg_tdata,
    input  logic [CH_W-1:0]       s_axis_cfg_tuser,
    input  logic                  s_axis_cfg_tvalid,
    output logic                  s_axis_cfg_tready,
    output logic [2*OUT_DW-1:0]   m_axis_tdata,
    output logic [CH_W-1:0]       m_axis_tuser,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast
);

    localparam int unsigned LUT_AW = PHASE_DW - 2;
    localparam int unsigned LUT_N  = 32'd1 << LUT_AW;
    localparam logic [OUT_DW-1:0] AMP = {1'b0, {(OUT_DW-1){1'b1}}};

    // First-quadrant sine magnitude, rounded to nearest
    function automatic logic [OUT_DW-1:0] lut_val(input int k);
        real ang;
        ang = 1.5707963267948966 * real'(k) / real'(LUT_N);
        return OUT_DW'($rtoi(real'(AMP) * $sin(ang) + 0.5));
    endfunction

    logic [OUT_DW-1:0] w_rom [LUT_N];

    for (genvar g = 0; g < int'(LUT_N); g++) begin : g_rom
        assign w_rom[g] = lut_val(g);
    end

    logic [PHASE_DW-1:0] r_acc [NUM_CH];
    logic [PHASE_DW-1:0] r_inc [NUM_CH];
    logic [PHASE_DW-1:0] r_off [NUM_CH];
    logic [CH_W-1:0]     r_ch;

    logic                w_advance;
    logic                w_issue;
    logic                w_cfg_we;
    logic [PHASE_DW-1:0] w_cfg_inc;
    logic [PHASE_DW-1:0] w_cfg_off;

    assign w_advance         = !m_axis_tvalid || m_axis_tready;
    assign w_issue           = w_advance && run;
    assign w_cfg_we          = s_axis_cfg_tvalid && (32'(s_axis_cfg_tuser) < NUM_CH);
    assign w_cfg_inc         = s_axis_cfg_tdata[PHASE_DW-1:0];
    assign w_cfg_off         = s_axis_cfg_tdata[2*PHASE_DW-1:PHASE_DW];
    assign s_axis_cfg_tready = 1'b1;

    // Per-channel tuning word / offset writes; an issue in the same cycle sees the old values
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int c = 0; c < int'(NUM_CH); c++) begin
                r_inc[c] <= '0;
                r_off[c] <= '0;
            end
        end else if (w_cfg_we) begin
            r_inc[s_axis_cfg_tuser] <= w_cfg_inc;
            r_off[s_axis_cfg_tuser] <= w_cfg_off;
        end
    end

    // Phase accumulators; a clear wins over the issuing channel's update
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int c = 0; c < int'(NUM_CH); c++) begin
                r_acc[c] <= '0;
            end
        end else if (phase_clear) begin
            for (int c = 0; c < int'(NUM_CH); c++) begin
                r_acc[c] <= '0;
            end
        end else if (w_issue) begin
            r_acc[r_ch] <= r_acc[r_ch] + r_inc[r_ch];
        end
    end

    // Round-robin channel sequencer
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ch <= '0;
        end else if (w_issue) begin
            r_ch <= (r_ch == CH_W'(NUM_CH - 1)) ? '0 : r_ch + CH_W'(1);
        end
    end

    logic                r_s1_vld;
    logic [PHASE_DW-1:0] r_s1_phase;
    logic [CH_W-1:0]     r_s1_ch;

    // Stage 1: issue, capture output phase of the selected channel
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s1_vld   <= 1'b0;
            r_s1_phase <= '0;
            r_s1_ch    <= '0;
        end else if (w_advance) begin
            r_s1_vld   <= run;
            r_s1_phase <= r_acc[r_ch] + r_off[r_ch];
            r_s1_ch    <= r_ch;
        end
    end

    logic [1:0]        w_s1_quad;
    logic [LUT_AW-1:0] w_s1_frac;
    logic [LUT_AW-1:0] w_s1_mirror;
    logic              w_s1_frac_zero;

    assign w_s1_quad      = r_s1_phase[PHASE_DW-1 -: 2];
    assign w_s1_frac      = r_s1_phase[LUT_AW-1:0];
    assign w_s1_mirror    = LUT_AW'(0) - w_s1_frac;
    assign w_s1_frac_zero = (w_s1_frac == '0);

    logic              r_s2_vld;
    logic [CH_W-1:0]   r_s2_ch;
    logic [LUT_AW-1:0] r_s2_sin_idx;
    logic [LUT_AW-1:0] r_s2_cos_idx;
    logic              r_s2_sin_full;
    logic              r_s2_cos_full;
    logic              r_s2_sin_neg;
    logic              r_s2_cos_neg;

    // Stage 2: quadrant fold; a mirrored zero index means the full-scale point
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s2_vld      <= 1'b0;
            r_s2_ch       <= '0;
            r_s2_sin_idx  <= '0;
            r_s2_cos_idx  <= '0;
            r_s2_sin_full <= 1'b0;
            r_s2_cos_full <= 1'b0;
            r_s2_sin_neg  <= 1'b0;
            r_s2_cos_neg  <= 1'b0;
        end else if (w_advance) begin
            r_s2_vld      <= r_s1_vld;
            r_s2_ch       <= r_s1_ch;
            r_s2_sin_idx  <= w_s1_quad[0] ? w_s1_mirror : w_s1_frac;
            r_s2_cos_idx  <= w_s1_quad[0] ? w_s1_frac : w_s1_mirror;
            r_s2_sin_full <= w_s1_quad[0] && w_s1_frac_zero;
            r_s2_cos_full <= !w_s1_quad[0] && w_s1_frac_zero;
            r_s2_sin_neg  <= w_s1_quad[1] ^ NEGATIVE_SINE;
            r_s2_cos_neg  <= w_s1_quad[1] ^ w_s1_quad[0];
        end
    end

    logic              r_s3_vld;
    logic [CH_W-1:0]   r_s3_ch;
    logic [OUT_DW-1:0] r_s3_sin_mag;
    logic [OUT_DW-1:0] r_s3_cos_mag;
    logic              r_s3_sin_neg;
    logic              r_s3_cos_neg;

    // Stage 3: LUT read of both magnitudes
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s3_vld     <= 1'b0;
            r_s3_ch      <= '0;
            r_s3_sin_mag <= '0;
            r_s3_cos_mag <= '0;
            r_s3_sin_neg <= 1'b0;
            r_s3_cos_neg <= 1'b0;
        end else if (w_advance) begin
            r_s3_vld     <= r_s2_vld;
            r_s3_ch      <= r_s2_ch;
            r_s3_sin_mag <= r_s2_sin_full ? AMP : w_rom[r_s2_sin_idx];
            r_s3_cos_mag <= r_s2_cos_full ? AMP : w_rom[r_s2_cos_idx];
            r_s3_sin_neg <= r_s2_sin_neg;
            r_s3_cos_neg <= r_s2_cos_neg;
        end
    end

    logic [OUT_DW-1:0] w_sin;
    logic [OUT_DW-1:0] w_cos;

    assign w_sin = r_s3_sin_neg ? (OUT_DW'(0) - r_s3_sin_mag) : r_s3_sin_mag;
    assign w_cos = r_s3_cos_neg ? (OUT_DW'(0) - r_s3_cos_mag) : r_s3_cos_mag;

    // Stage 4: signed output register; payload held while the sink stalls
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tuser  <= '0;
            m_axis_tlast  <= 1'b0;
        end else if (w_advance) begin
            m_axis_tvalid <= r_s3_vld;
            if (r_s3_vld) begin
                m_axis_tdata <= {w_sin, w_cos};
                m_axis_tuser <= r_s3_ch;
                m_axis_tlast <= (r_s3_ch == CH_W'(NUM_CH - 1));
            end
        end
    end

endmodule

// File: tb/tb_nco_mc.sv
// tb_nco_mc: checks nco_mc (normal and inverted-sine builds) against a
// cycle-level behavioural model plus hand-computed literal samples.
module tb_nco_mc;

    localparam int  PDW     = 16;
    localparam int  ODW     = 16;
    localparam int  NCH     = 4;
    localparam int  CW      = 2;
    localparam int  QN      = 1 << (PDW - 2);
    localparam int  MASK    = (1 << PDW) - 1;
    localparam real HALF_PI = 1.5707963267948966;

    logic            clk         = 1'b0;
    logic            reset_n     = 1'b0;
    logic            run         = 1'b0;
    logic            phase_clear = 1'b0;
    logic [2*PDW-1:0] cfg_tdata  = '0;
    logic [CW-1:0]   cfg_tuser   = '0;
    logic            cfg_tvalid  = 1'b0;
    logic            tready      = 1'b1;

    logic            cfg_tready_a, cfg_tready_b;
    logic [2*ODW-1:0] td_a, td_b;
    logic [CW-1:0]   tu_a, tu_b;
    logic            tv_a, tv_b, tl_a, tl_b;

    int n_cmp = 0;
    int n_err = 0;

    nco_mc #(.PHASE_DW(PDW), .OUT_DW(ODW), .NUM_CH(NCH), .NEGATIVE_SINE(1'b0)) u_dut_a (
        .clk(clk), .reset_n(reset_n), .run(run), .phase_clear(phase_clear),
        .s_axis_cfg_tdata(cfg_tdata), .s_axis_cfg_tuser(cfg_tuser),
        .s_axis_cfg_tvalid(cfg_tvalid), .s_axis_cfg_tready(cfg_tready_a),
        .m_axis_tdata(td_a), .m_axis_tuser(tu_a), .m_axis_tvalid(tv_a),
        .m_axis_tready(tready), .m_axis_tlast(tl_a)
    );

    nco_mc #(.PHASE_DW(PDW), .OUT_DW(ODW), .NUM_CH(NCH), .NEGATIVE_SINE(1'b1)) u_dut_b (
        .clk(clk), .reset_n(reset_n), .run(run), .phase_clear(phase_clear),
        .s_axis_cfg_tdata(cfg_tdata), .s_axis_cfg_tuser(cfg_tuser),
        .s_axis_cfg_tvalid(cfg_tvalid), .s_axis_cfg_tready(cfg_tready_b),
        .m_axis_tdata(td_b), .m_axis_tuser(tu_b), .m_axis_tvalid(tv_b),
        .m_axis_tready(tready), .m_axis_tlast(tl_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, req, $time);
        end
    endtask

    // Quarter-wave magnitude for k in 0..QN (k = QN is full scale)
    function automatic int amp(input int k);
        return $rtoi(32767.0 * $sin(HALF_PI * real'(k) / real'(QN)) + 0.5);
    endfunction

    // sin(2*pi*p/2^PDW) by quadrant symmetry
    function automatic int sin_ref(input int p);
        int q, f, m;
        q = (p >> (PDW - 2)) & 3;
        f = p & (QN - 1);
        m = (q % 2 == 1) ? amp(QN - f) : amp(f);
        return (q >= 2) ? -m : m;
    endfunction

    function automatic int cos_ref(input int p);
        return sin_ref((p + QN) & MASK);
    endfunction

    // Behavioural model: per-channel arithmetic plus a 4-deep latency line
    int m_acc [NCH];
    int m_inc [NCH];
    int m_off [NCH];
    int mdl_ch = 0;
    bit pv  [4] = '{0, 0, 0, 0};
    int pph [4] = '{0, 0, 0, 0};
    int pch [4] = '{0, 0, 0, 0};

    always @(posedge clk or negedge reset_n) begin
        bit adv;
        int t;
        if (!reset_n) begin
            for (int c = 0; c < NCH; c++) begin
                m_acc[c] = 0; m_inc[c] = 0; m_off[c] = 0;
            end
            mdl_ch = 0;
            for (int s = 0; s < 4; s++) begin
                pv[s] = 1'b0; pph[s] = 0; pch[s] = 0;
            end
        end else begin
            adv = !pv[3] || tready;
            if (adv) begin
                for (int s = 3; s > 0; s--) begin
                    pv[s] = pv[s-1]; pph[s] = pph[s-1]; pch[s] = pch[s-1];
                end
                pv[0] = run;
                if (run) begin
                    pph[0] = (m_acc[mdl_ch] + m_off[mdl_ch]) & MASK;
                    pch[0] = mdl_ch;
                    m_acc[mdl_ch] = (m_acc[mdl_ch] + m_inc[mdl_ch]) & MASK;
                    mdl_ch = (mdl_ch + 1) % NCH;
                end
            end
            t = int'(cfg_tuser);
            if (cfg_tvalid && t < NCH) begin
                m_inc[t] = int'(cfg_tdata[PDW-1:0]);
                m_off[t] = int'(cfg_tdata[2*PDW-1:PDW]);
            end
            if (phase_clear) begin
                for (int c = 0; c < NCH; c++) m_acc[c] = 0;
            end
        end
    end

    typedef struct {
        int ch;
        int s;
        int c;
        int sn;
        int last;
    } cap_t;
    cap_t cap_q [$];

    // Per-cycle compare against the model, plus capture of accepted samples
    always begin
        int sa, ca, sb, cb;
        cap_t e;
        @(negedge clk);
        #2;
        sa = int'($signed(td_a[2*ODW-1:ODW]));
        ca = int'($signed(td_a[ODW-1:0]));
        sb = int'($signed(td_b[2*ODW-1:ODW]));
        cb = int'($signed(td_b[ODW-1:0]));
        chk("tvalid", int'(tv_a), int'(pv[3]));
        chk("tvalid_negsine", int'(tv_b), int'(pv[3]));
        if (!reset_n) begin
            chk("rst_tdata", int'(td_a), 0);
        end else if (pv[3]) begin
            chk("tuser", int'(tu_a), pch[3]);
            chk("tlast", int'(tl_a), int'(pch[3] == NCH - 1));
            chk("sin", sa, sin_ref(pph[3]));
            chk("cos", ca, cos_ref(pph[3]));
            chk("tuser_negsine", int'(tu_b), pch[3]);
            chk("sin_negsine", sb, -sin_ref(pph[3]));
            chk("cos_negsine", cb, cos_ref(pph[3]));
        end
        if (tv_a && tready) begin
            e.ch = int'(tu_a); e.s = sa; e.c = ca; e.sn = sb; e.last = int'(tl_a);
            cap_q.push_back(e);
        end
    end

    task automatic cfg_wr(input int ch, input int inc, input int off);
        cfg_tuser  = CW'(ch);
        cfg_tdata  = {PDW'(off), PDW'(inc)};
        cfg_tvalid = 1'b1;
        @(negedge clk);
        cfg_tvalid = 1'b0;
    endtask

    int s0 [4]    = '{0, 32767, 0, -32767};
    int c0 [4]    = '{32767, 0, -32767, 0};
    int e2s [3]   = '{0, 0, 32767};
    int e2c [3]   = '{32767, 32767, 0};
    int clr_s [4] = '{0, 32767, 0, 804};
    int clr_c [4] = '{32767, 0, 32767, 32757};

    initial begin
        int lat, g, k;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_tvalid", int'(tv_a), 0);
        chk("rst_tuser", int'(tu_a), 0);
        chk("rst_tlast", int'(tl_a), 0);
        chk("cfg_tready", int'(cfg_tready_a), 1);
        reset_n = 1'b1;

        cfg_wr(0, 'h4000, 0);
        cfg_wr(1, 0, 'h4000);
        cfg_wr(2, 0, 0);
        cfg_wr(3, 'h1234, 'h0100);

        // Issue-to-output latency and first frames
        cap_q.delete();
        run = 1'b1;
        lat = 0;
        while (!tv_a && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", lat, 4);
        repeat (18) @(negedge clk);
        chk("frame_count", int'(cap_q.size() >= 16), 1);
        for (int i = 0; i < 16 && i < cap_q.size(); i++) begin
            chk("pin_tuser", cap_q[i].ch, i % 4);
            chk("pin_tlast", cap_q[i].last, int'(i % 4 == 3));
            if (i % 4 == 0) begin
                chk("pin_ch0_sin", cap_q[i].s, s0[i/4]);
                chk("pin_ch0_cos", cap_q[i].c, c0[i/4]);
            end
            if (i % 4 == 1) begin
                chk("pin_ch1_sin", cap_q[i].s, 32767);
                chk("pin_ch1_cos", cap_q[i].c, 0);
                chk("pin_ch1_negsine", cap_q[i].sn, -32767);
            end
        end

        // Ten-cycle sink stall mid-stream
        tready = 1'b0;
        repeat (10) @(negedge clk);
        tready = 1'b1;
        repeat (12) @(negedge clk);

        // Config write colliding with the ch2 issue
        run = 1'b0;
        repeat (6) @(negedge clk);
        cap_q.delete();
        run = 1'b1;
        g = 0;
        while (mdl_ch != 2 && g < 8) begin
            @(negedge clk);
            g++;
        end
        chk("ch2_sync", mdl_ch, 2);
        cfg_wr(2, 'h4000, 0);
        repeat (16) @(negedge clk);
        k = 0;
        foreach (cap_q[i]) begin
            if (cap_q[i].ch == 2 && k < 3) begin
                chk("pin_ch2_sin", cap_q[i].s, e2s[k]);
                chk("pin_ch2_cos", cap_q[i].c, e2c[k]);
                k++;
            end
        end
        chk("pin_ch2_count", k, 3);

        // Phase clear while stalled
        repeat (5) @(negedge clk);
        tready = 1'b0;
        repeat (6) @(negedge clk);
        phase_clear = 1'b1;
        @(negedge clk);
        phase_clear = 1'b0;
        repeat (3) @(negedge clk);
        cap_q.delete();
        tready = 1'b1;
        repeat (16) @(negedge clk);
        chk("clr_count", int'(cap_q.size() >= 8), 1);
        for (int i = 4; i < 8 && i < cap_q.size(); i++) begin
            chk("pin_clr_sin", cap_q[i].s, clr_s[cap_q[i].ch]);
            chk("pin_clr_cos", cap_q[i].c, clr_c[cap_q[i].ch]);
        end

        // Reset mid-stream
        repeat (5) @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("midrst_tvalid", int'(tv_a), 0);
        chk("midrst_tvalid_negsine", int'(tv_b), 0);
        repeat (2) @(negedge clk);
        cap_q.delete();
        reset_n = 1'b1;
        repeat (8) @(negedge clk);
        chk("post_rst_count", int'(cap_q.size() >= 1), 1);
        if (cap_q.size() >= 1) begin
            chk("post_rst_ch", cap_q[0].ch, 0);
            chk("post_rst_sin", cap_q[0].s, 0);
            chk("post_rst_cos", cap_q[0].c, 32767);
            chk("post_rst_negsine", cap_q[0].sn, 0);
        end

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            run         = ($urandom_range(0, 9) < 8);
            tready      = ($urandom_range(0, 9) < 7);
            phase_clear = ($urandom_range(0, 99) < 3);
            cfg_tvalid  = ($urandom_range(0, 9) < 2);
            cfg_tuser   = CW'($urandom_range(0, NCH - 1));
            cfg_tdata   = $urandom;
            @(negedge clk);
        end
        phase_clear = 1'b0;
        cfg_tvalid  = 1'b0;
        tready      = 1'b1;
        repeat (8) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/nco_mc.md
NCO_MC -- requirements
Module: nco_mc

Interface
REQ-001 SHALL have parameter PHASE_DW, default 16, meaning phase accumulator, tuning word and offset width (min 4).
REQ-002 SHALL have parameter OUT_DW, default 16, meaning signed sin/cos sample width.
REQ-003 SHALL have parameter NUM_CH, default 4, meaning number of time-multiplexed channels (min 1).
REQ-004 SHALL have parameter NEGATIVE_SINE, default 0, meaning invert sine output when 1.
REQ-005 SHALL derive localparam CH_W = max(1, clog2(NUM_CH)), not overridable.
REQ-006 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-007 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-008 SHALL have port run  input  1  when high, sequencer issues channels.
REQ-009 SHALL have port phase_clear  input  1  one-cycle pulse zeroing all accumulators.
REQ-010 SHALL have port s_axis_cfg_tdata  input  2*PHASE_DW  {offset[PHASE_DW-1:0], increment[PHASE_DW-1:0]} (increment in LSBs).
REQ-011 SHALL have port s_axis_cfg_tuser  input  CH_W  target channel.
REQ-012 SHALL have port s_axis_cfg_tvalid  input  1  config write strobe.
REQ-013 SHALL have port s_axis_cfg_tready  output  1  tied high.
REQ-014 SHALL have port m_axis_tdata  output  2*OUT_DW  {sin, cos}, sin in MSBs.
REQ-015 SHALL have port m_axis_tuser  output  CH_W  channel index of sample.
REQ-016 SHALL have ports m_axis_tvalid  output  1, m_axis_tready  input  1, and m_axis_tlast  output  1 (high on channel NUM_CH-1).

Function
REQ-017 SHALL hold per channel: accumulator acc[c], increment inc[c], offset off[c], all PHASE_DW unsigned.
REQ-018 SHALL define advance = !m_axis_tvalid_internal_full || m_axis_tready; when advance=0 every pipeline stage, the sequencer and all accumulators SHALL hold.
REQ-019 SHALL, on an advancing cycle with run=1, issue channel ch (round-robin counter 0..NUM_CH-1, wraps to 0): phase = acc[ch]+off[ch] mod 2^PHASE_DW; acc[ch] <= acc[ch]+inc[ch] mod 2^PHASE_DW.
REQ-020 SHALL not issue or advance the channel counter while run=0; in-flight samples still drain.
REQ-021 SHALL produce the output sample exactly 4 advancing cycles after issue (issue -> quadrant/index -> LUT read -> sign/output register).
REQ-022 SHALL use a quarter-wave LUT of 2^(PHASE_DW-2) signed OUT_DW entries; quadrant = phase[PHASE_DW-1:PHASE_DW-2]; mirrored index in quadrants 2/4 (sine) and 1/3 (cosine); index 0 in a mirrored quadrant yields 2^(OUT_DW-1)-1.
REQ-023 SHALL output sin negated in quadrants 3/4, cos negated in quadrants 2/3; NEGATIVE_SINE=1 additionally negates sin; results SHALL never exceed ±(2^(OUT_DW-1)-1).
REQ-024 SHALL write inc/off of channel s_axis_cfg_tuser on every cycle s_axis_cfg_tvalid=1; tuser >= NUM_CH SHALL be ignored.
REQ-025 SHALL, when a config write targets the channel issued in the same cycle, use old inc/off for that issue; new values apply from the next visit.
REQ-026 SHALL, on phase_clear=1, set every acc[c] to 0 regardless of advance; takes priority over a simultaneous accumulator update; channel counter unaffected.
REQ-027 SHALL keep m_axis_tdata/tuser/tlast stable while m_axis_tvalid=1 and m_axis_tready=0; no sample dropped or duplicated.

Reset
REQ-028 SHALL, while reset_n=0, clear acc, inc, off, channel counter, all pipeline valids, m_axis_tvalid=0, m_axis_tdata=0, m_axis_tuser=0, m_axis_tlast=0.
REQ-029 SHALL clear in-flight samples on reset assertion mid-operation; first output after release is channel 0 with acc=0.
REQ-030 SHALL not require LUT contents to be reset.

Verification
REQ-031 SHALL verify: PHASE_DW=16, NUM_CH=4, inc[0]=0x4000, off=0, run=1, tready=1 -> ch0 sin sequence 0, 32767, 0, -32767, cos 32767, 0, -32767, 0; tuser cycles 0,1,2,3; tlast on ch3.
REQ-032 SHALL verify: inc[1]=0, off[1]=0x4000 -> ch1 every frame sin=32767, cos=0; NEGATIVE_SINE=1 -> sin=-32767.
REQ-033 SHALL verify: tready low 10 cycles mid-stream -> tdata/tuser frozen, sample order and accumulator values continue with no gap or repeat after tready rises.
REQ-034 SHALL verify: config write to ch2 in the same cycle ch2 issues -> that sample uses old inc, next ch2 sample reflects new inc.
REQ-035 SHALL verify: phase_clear pulse with tready=0 -> subsequent samples of every channel start from phase off[c]; reset_n low mid-stream -> tvalid=0 within the same cycle, first post-reset sample ch0 sin=0, cos=32767.
